// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator for a byte-addressed data memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being split into byte beats.
module lsu_ctrl #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic [31:0] w_dat,
    output logic [2:0]  funct,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] r_dat
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      r_state, w_next;
    logic        r_we, r_split, r_err;
    logic [2:0]  r_funct;
    logic [31:0] r_addr, r_wdata, r_acc, r_rdata;
    logic [1:0]  r_beat, r_nlast;
    logic [1:0]  w_sz_m1;
    logic [32:0] w_end;
    logic        w_illegal, w_oor, w_mis, w_err, w_split, w_last, w_issue;
    logic [7:0]  w_wbyte;
    logic [31:0] w_acc, w_ext;
    assign w_sz_m1   = req_funct[1:0] == 2'b00 ? 2'd0 : req_funct[1:0] == 2'b01 ? 2'd1 : 2'd3;
    assign w_illegal = req_we ? (req_funct > 3'b010) : (req_funct[1:0] == 2'b11 || req_funct[2:1] == 2'b11);
    // 33-bit end address so accesses near 2^32 cannot wrap back into range
    assign w_end     = {1'b0, req_addr} + {31'b0, w_sz_m1};
    assign w_oor     = w_end >= 33'(MEM_BYTES);
    assign w_mis     = (req_funct[1:0] == 2'b01 && req_addr[0]) || (req_funct[1:0] == 2'b10 && |req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_err     = w_illegal | w_oor | w_mis;
    assign w_split   = 1'b0;
`else
    assign w_err     = w_illegal | w_oor;
    assign w_split   = w_mis;
`endif
    assign w_last    = r_beat == r_nlast;
    assign w_issue   = r_state == ISSUE;
    assign w_wbyte   = r_wdata[{r_beat, 3'b000} +: 8];
    assign req_ready = r_state == IDLE;
    assign resp_valid = r_state == RESP;
    assign resp_err  = resp_valid & r_err;
    assign resp_rdata = r_rdata;
    assign mem_read  = w_issue & ~r_we;
    assign mem_write = w_issue & r_we;
    assign addr      = w_issue ? r_addr + {30'b0, r_beat} : 32'b0;
    assign w_dat     = mem_write ? (r_split ? {24'b0, w_wbyte} : r_wdata) : 32'b0;
    // loads always use the unsigned memory code; extension is applied locally
    assign funct     = !w_issue ? 3'b000 : r_split ? {~r_we, 2'b00} :
                       r_we ? {1'b0, r_funct[1:0]} : r_funct[1] ? 3'b010 : {1'b1, r_funct[1:0]};
    always_comb begin
        w_acc = r_split ? r_acc : r_dat;
        if (r_split)
            w_acc[{r_beat, 3'b000} +: 8] = r_dat[7:0];
    end
    assign w_ext = r_funct == 3'b000 ? {{24{w_acc[7]}}, w_acc[7:0]} :
                   r_funct == 3'b001 ? {{16{w_acc[15]}}, w_acc[15:0]} :
                   r_funct == 3'b100 ? {24'b0, w_acc[7:0]} :
                   r_funct == 3'b101 ? {16'b0, w_acc[15:0]} : w_acc;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !req_valid ? IDLE : w_err ? RESP : ISSUE;
            ISSUE:   w_next = !r_we ? WAIT : w_last ? RESP : ISSUE;
            WAIT:    w_next = w_last ? RESP : ISSUE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_funct <= 3'b0;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_acc   <= 32'b0;
            r_rdata <= 32'b0;
            r_beat  <= 2'b0;
            r_nlast <= 2'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_funct <= req_funct;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_split <= w_split;
                    r_nlast <= w_split ? w_sz_m1 : 2'd0;
                    r_err   <= w_err;
                    r_beat  <= 2'd0;
                    r_acc   <= 32'b0;
                    if (w_err)
                        r_rdata <= 32'b0;
                end
                ISSUE: if (r_we) begin
                    if (w_last)
                        r_rdata <= 32'b0;
                    else
                        r_beat <= r_beat + 2'd1;
                end
                WAIT: begin
                    r_acc <= w_acc;
                    if (w_last)
                        r_rdata <= w_ext;
                    else
                        r_beat <= r_beat + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-array reference model.
module tb_lsu_ctrl;
    localparam int MB = 4096;
    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0, r_dat = 32'b0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, addr, w_dat;
    logic [2:0]  funct;
    logic [7:0]  mem [MB];
    logic [7:0]  ref_mem [MB];
    bit          mem_init = 1'b0;
    int          mw_n;
    logic [31:0] mr_v;
    int          checks = 0, errors = 0;
    logic [31:0] b_addr[$], b_wd[$];
    logic [2:0]  b_fn[$];
    always #5 clk = ~clk;
    lsu_ctrl #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .addr(addr), .w_dat(w_dat), .funct(funct),
        .mem_read(mem_read), .mem_write(mem_write), .r_dat(r_dat)
    );
    function automatic logic [7:0] init_b(int i);
        return 8'(i * 37 + 11);
    endfunction
    // memory port: writes commit on posedge, read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < MB; i++) mem[i] = init_b(i);
            mem_init = 1'b1;
        end
        mw_n = funct[1:0] == 2'b00 ? 1 : funct[1:0] == 2'b01 ? 2 : 4;
        if (mem_write)
            for (int k = 0; k < mw_n; k++) mem[12'(addr + 32'(k))] = w_dat[8*k +: 8];
        if (mem_read) begin
            mr_v = 32'b0;
            for (int k = 0; k < mw_n; k++) mr_v[8*k +: 8] = mem[12'(addr + 32'(k))];
            r_dat <= mr_v;
        end
    end
    task automatic model(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int lat, output int nst);
        int sz, nb;
        bit ill, oor, mis;
        logic [31:0] v;
        sz  = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
        ill = we ? (f > 3'd2) : (f == 3'd3 || f >= 3'd6);
        oor = (64'(a) + 64'(sz)) > 64'(MB);
        mis = (a % 32'(sz)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        e = ill | oor | mis;
`else
        e = ill | oor;
`endif
        rd = 32'b0; lat = 1; nst = 0;
        if (!e) begin
            nb  = mis ? sz : 1;
            nst = nb;
            lat = we ? nb + 1 : 2 * nb + 1;
            if (we)
                for (int k = 0; k < sz; k++) ref_mem[12'(a + 32'(k))] = wd[8*k +: 8];
            else begin
                v = 32'b0;
                for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[12'(a + 32'(k))];
                rd = f == 3'd0 ? {{24{v[7]}}, v[7:0]} : f == 3'd1 ? {{16{v[15]}}, v[15:0]} : v;
            end
        end
    endtask
    task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e, output logic [31:0] rd, output int nst);
        int t;
        b_addr.delete(); b_wd.delete(); b_fn.delete();
        lat = 99; nst = 0; e = 1'bx; rd = 32'bx; t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        req_valid = 1'b1; req_we = we; req_funct = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                nst++;
                b_addr.push_back(addr); b_fn.push_back(funct); b_wd.push_back(w_dat);
            end
            if (resp_valid) begin
                lat = c; e = resp_err; rd = resp_rdata;
                break;
            end
        end
    endtask
    task automatic test_reset();
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write, funct, addr, w_dat, resp_rdata} !== {1'b1, 103'b0}) begin
            errors++; $display("FAIL reset_in: outputs=%h want %h", {req_ready, resp_valid, resp_err, mem_read, mem_write, funct, addr, w_dat, resp_rdata}, {1'b1, 103'b0});
        end
        checks++;
        @(negedge clk) rst = 1'b0;
        #1;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write, funct, addr, w_dat, resp_rdata} !== {1'b1, 103'b0}) begin
            errors++; $display("FAIL reset_out: outputs=%h", {req_ready, resp_valid, resp_err, mem_read, mem_write, funct, addr, w_dat, resp_rdata});
        end
        checks++;
    endtask
    task automatic test_word();
        int lat, nst, el, en; logic e, ee; logic [31:0] rd, er;
        model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ee, er, el, en);
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, e, rd, nst);
        if (lat !== 2 || nst !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL sw_aligned: lat=%0d nst=%0d err=%b want 2 1 0", lat, nst, e);
        end
        checks++;
        if (b_fn.size() != 1 || b_fn[0] !== 3'b010 || b_addr[0] !== 32'h10 || b_wd[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_beat: beats=%0d", b_fn.size());
        end
        checks++;
        model(1'b0, 3'b010, 32'h10, 32'h0, ee, er, el, en);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, e, rd, nst);
        if (lat !== 3 || nst !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_aligned: lat=%0d nst=%0d err=%b rdata=%h want 3 1 0 deadbeef", lat, nst, e, rd);
        end
        checks++;
        @(negedge clk);
        if (resp_rdata !== 32'hDEADBEEF || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rdata_hold: rdata=%h valid=%b want deadbeef 0", resp_rdata, resp_valid);
        end
        checks++;
    endtask
    task automatic test_byte_ext();
        int lat, nst, el, en; logic e, ee; logic [31:0] rd, er;
        model(1'b1, 3'b000, 32'h20, 32'h12345680, ee, er, el, en);
        do_req(1'b1, 3'b000, 32'h20, 32'h12345680, lat, e, rd, nst);
        model(1'b0, 3'b000, 32'h20, 32'h0, ee, er, el, en);
        do_req(1'b0, 3'b000, 32'h20, 32'h0, lat, e, rd, nst);
        if (rd !== 32'hFFFFFF80 || lat !== 3 || b_fn.size() != 1 || b_fn[0] !== 3'b100) begin
            errors++; $display("FAIL lb_sext: rdata=%h lat=%0d want ffffff80 3", rd, lat);
        end
        checks++;
        do_req(1'b0, 3'b100, 32'h20, 32'h0, lat, e, rd, nst);
        if (rd !== 32'h00000080 || e !== 1'b0) begin
            errors++; $display("FAIL lbu_zext: rdata=%h err=%b want 00000080 0", rd, e);
        end
        checks++;
    endtask
    task automatic test_misaligned();
        int lat, nst, el, en; logic e, ee; logic [31:0] rd, er;
        model(1'b1, 3'b010, 32'h31, 32'h11223344, ee, er, el, en);
        do_req(1'b1, 3'b010, 32'h31, 32'h11223344, lat, e, rd, nst);
        if (lat !== el || nst !== en || e !== ee) begin
            errors++; $display("FAIL sw_mis: lat=%0d nst=%0d err=%b want %0d %0d %b", lat, nst, e, el, en, ee);
        end
        checks++;
        for (int k = 0; k < b_fn.size(); k++) begin
            if (b_addr[k] !== 32'h31 + 32'(k) || b_fn[k] !== 3'b000 || b_wd[k][7:0] !== 8'(32'h11223344 >> (8 * k))) begin
                errors++; $display("FAIL sw_mis_beat%0d: addr=%h fn=%b wd=%h", k, b_addr[k], b_fn[k], b_wd[k]);
            end
            checks++;
        end
        model(1'b0, 3'b010, 32'h31, 32'h0, ee, er, el, en);
        do_req(1'b0, 3'b010, 32'h31, 32'h0, lat, e, rd, nst);
        if (lat !== el || nst !== en || e !== ee || rd !== er) begin
            errors++; $display("FAIL lw_mis: lat=%0d nst=%0d err=%b rdata=%h want %0d %0d %b %h", lat, nst, e, rd, el, en, ee, er);
        end
        checks++;
        for (int k = 0; k < b_fn.size(); k++) begin
            if (b_addr[k] !== 32'h31 + 32'(k) || b_fn[k] !== 3'b100) begin
                errors++; $display("FAIL lw_mis_beat%0d: addr=%h fn=%b", k, b_addr[k], b_fn[k]);
            end
            checks++;
        end
    endtask
    task automatic test_errors();
        int lat, nst, el, en; logic e, ee; logic [31:0] rd, er;
        logic we [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] fs [6] = '{3'b010, 3'b011, 3'b010, 3'b011, 3'b000, 3'b001};
        logic [31:0] as [6] = '{32'hFFE, 32'h40, 32'hFFC, 32'h44, 32'hFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            model(we[i], fs[i], as[i], 32'hCAFEF00D, ee, er, el, en);
            do_req(we[i], fs[i], as[i], 32'hCAFEF00D, lat, e, rd, nst);
            if (lat !== el || nst !== en || e !== ee || rd !== er) begin
                errors++; $display("FAIL err_case%0d: lat=%0d nst=%0d err=%b rdata=%h want %0d %0d %b %h", i, lat, nst, e, rd, el, en, ee, er);
            end
            checks++;
        end
    endtask
    task automatic test_reset_abort();
        int nrsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct = 3'b010; req_addr = 32'h51; req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write, funct, addr, w_dat} !== {1'b1, 71'b0}) begin
            errors++; $display("FAIL abort_outputs: outputs=%h", {req_ready, resp_valid, resp_err, mem_read, mem_write, funct, addr, w_dat});
        end
        checks++;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) nrsp++;
        end
        if (nrsp !== 0) begin
            errors++; $display("FAIL abort_noresp: responses=%0d want 0", nrsp);
        end
        checks++;
`ifndef LSU_MISALIGN_TRAP_EN
        ref_mem[12'h51] = 8'hDD;
`endif
        if (mem[12'h51] !== ref_mem[12'h51] || mem[12'h52] !== ref_mem[12'h52]) begin
            errors++; $display("FAIL abort_bytes: mem51=%h mem52=%h want %h %h", mem[12'h51], mem[12'h52], ref_mem[12'h51], ref_mem[12'h52]);
        end
        checks++;
    endtask
    task automatic test_back_to_back();
        int acc = 0, rsp = 0, both = 0, el, en; logic ee; logic [31:0] er;
        model(1'b1, 3'b010, 32'h80, 32'h5A5AA5A5, ee, er, el, en);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct = 3'b010; req_addr = 32'h80; req_wdata = 32'h5A5AA5A5;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req_ready) acc++;
            if (resp_valid) rsp++;
            if (req_ready && resp_valid) both++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (resp_valid) rsp++;
            @(negedge clk);
        end
        if (acc !== 10 || rsp !== 10 || both !== 0) begin
            errors++; $display("FAIL back_to_back: accepts=%0d responses=%0d overlap=%0d want 10 10 0", acc, rsp, both);
        end
        checks++;
    endtask
    task automatic test_random();
        int lat, nst, el, en, pick; logic e, ee, we; logic [2:0] f; logic [31:0] rd, er, a, wd;
        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            f = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a = pick == 0 ? 32'hFF8 + 32'($urandom_range(0, 7)) : pick == 1 ? $urandom : 32'($urandom_range(256, 511));
            wd = $urandom;
            model(we, f, a, wd, ee, er, el, en);
            do_req(we, f, a, wd, lat, e, rd, nst);
            if (lat !== el || nst !== en || e !== ee || rd !== er) begin
                errors++; $display("FAIL rand%0d we=%b f=%b a=%h: lat=%0d nst=%0d err=%b rdata=%h want %0d %0d %b %h", i, we, f, a, lat, nst, e, rd, el, en, ee, er);
            end
            checks++;
        end
    endtask
    initial begin
        int nbad;
        for (int i = 0; i < MB; i++) ref_mem[i] = init_b(i);
        repeat (2) @(negedge clk);
        test_reset();
        test_word();
        test_byte_ext();
        test_misaligned();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_random();
        nbad = 0;
        for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) nbad++;
        if (nbad !== 0) begin
            errors++; $display("FAIL mem_image: %0d differing bytes, want 0", nbad);
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
